// File: rtl/coin_acceptor_tx.sv
// rtl/coin_acceptor_tx.sv - coin sensor debounce, credit queue and pulse emitter
// Raw sensors are synchronised, debounced and queued; one clean pulse per coin is emitted.
module coin_acceptor_tx #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES      = 4,
  parameter int CREDIT_W        = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic nickel_raw,
  input  logic dime_raw,
  input  logic accept_en,
  input  logic tx_hold,
  output logic nickel_in,
  output logic dime_in,
  output logic coin_reject,
  output logic busy
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [CREDIT_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  // Index 0 = nickel, index 1 = dime throughout the front end.
  logic [1:0]    raw, sync1, sync2, deb, deb_d, ev;
  logic [DW-1:0] db_cnt [2];

  assign raw = {dime_raw, nickel_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb       <= '0;
      deb_d     <= '0;
      ev        <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      deb_d <= deb;
      ev    <= deb & ~deb_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt[i] <= '0;
          deb[i]    <= ~deb[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  logic [CREDIT_W-1:0] nickel_pend, dime_pend;
  logic                n_inc, d_inc, n_rej, d_rej;
  logic                n_dec, d_dec;
  logic                nickel_nxt, dime_nxt;
  state_t              state, state_nxt;
  logic [GW-1:0]       gap_cnt;

  always_comb begin
    n_inc = ev[0] & accept_en & (nickel_pend != PEND_MAX);
    d_inc = ev[1] & accept_en & (dime_pend != PEND_MAX);
    n_rej = ev[0] & (~accept_en | (nickel_pend == PEND_MAX));
    d_rej = ev[1] & (~accept_en | (dime_pend == PEND_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nickel_pend <= '0;
      dime_pend   <= '0;
      coin_reject <= 1'b0;
    end else begin
      coin_reject <= n_rej | d_rej;
      case ({n_inc, n_dec})
        2'b10:   nickel_pend <= nickel_pend + CREDIT_W'(1);
        2'b01:   nickel_pend <= nickel_pend - CREDIT_W'(1);
        default: nickel_pend <= nickel_pend;
      endcase
      case ({d_inc, d_dec})
        2'b10:   dime_pend <= dime_pend + CREDIT_W'(1);
        2'b01:   dime_pend <= dime_pend - CREDIT_W'(1);
        default: dime_pend <= dime_pend;
      endcase
    end
  end

  // Emitter state register; gap_cnt only runs while in GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= (state == GAP) ? gap_cnt + GW'(1) : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (n_dec | d_dec) state_nxt = PULSE;
      PULSE:   state_nxt = GAP;
      GAP:     if (gap_cnt == GW'(GAP_CYCLES - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Launch decode: dime wins; the counter drops on the edge the pulse is registered.
  always_comb begin
    d_dec      = (state == IDLE) & ~tx_hold & (dime_pend != '0);
    n_dec      = (state == IDLE) & ~tx_hold & (dime_pend == '0) & (nickel_pend != '0);
    dime_nxt   = d_dec;
    nickel_nxt = n_dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nickel_in <= 1'b0;
      dime_in   <= 1'b0;
    end else begin
      nickel_in <= nickel_nxt;
      dime_in   <= dime_nxt;
    end
  end

  assign busy = (nickel_pend != '0) | (dime_pend != '0) | (state != IDLE);

endmodule

// File: tb/tb_coin_acceptor_tx.sv
// tb/tb_coin_acceptor_tx.sv - directed self-checking bench for coin_acceptor_tx
module tb_coin_acceptor_tx;

  logic clk = 1'b0;
  logic rst_n, nickel_raw, dime_raw, accept_en, tx_hold;
  logic nickel_in, dime_in, coin_reject, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_rej = 0;
  int both_hi = 0;
  int ev_cyc[$];
  int ev_typ[$];
  int t0;

  coin_acceptor_tx dut (
    .clk(clk), .rst_n(rst_n), .nickel_raw(nickel_raw), .dime_raw(dime_raw),
    .accept_en(accept_en), .tx_hold(tx_hold), .nickel_in(nickel_in),
    .dime_in(dime_in), .coin_reject(coin_reject), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Pulse log sampled on the falling edge: type 2 = dime, 1 = nickel.
  always @(negedge clk) begin
    if (nickel_in && dime_in) both_hi++;
    if (dime_in) begin ev_cyc.push_back(cyc); ev_typ.push_back(2); end
    if (nickel_in) begin ev_cyc.push_back(cyc); ev_typ.push_back(1); end
    if (coin_reject) n_rej++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    ev_cyc.delete();
    ev_typ.delete();
    n_rej = 0;
  endtask

  task automatic insert(input bit d, input bit n);
    dime_raw = d;
    nickel_raw = n;
    tick(25);
    dime_raw = 1'b0;
    nickel_raw = 1'b0;
    tick(25);
  endtask

  function automatic int count_typ(input int t);
    int c = 0;
    foreach (ev_typ[i]) if (ev_typ[i] == t) c++;
    return c;
  endfunction

  function automatic int seq_code();
    int s = 0;
    foreach (ev_typ[i]) s = s * 10 + ev_typ[i];
    return s;
  endfunction

  function automatic int min_space();
    int m = 1000;
    for (int i = 1; i < ev_cyc.size(); i++)
      if (ev_cyc[i] - ev_cyc[i-1] < m) m = ev_cyc[i] - ev_cyc[i-1];
    return m;
  endfunction

  initial begin
    rst_n = 1'b0;
    nickel_raw = 1'b0;
    dime_raw = 1'b0;
    accept_en = 1'b1;
    tx_hold = 1'b0;
    tick(3);
    check("rst_nickel_in", nickel_in, 0);
    check("rst_dime_in", dime_in, 0);
    check("rst_coin_reject", coin_reject, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick(5);

    // 1: clean nickel, latency DEBOUNCE_CYCLES+5 = 21
    clear_log();
    t0 = cyc;
    nickel_raw = 1'b1;
    tick(40);
    nickel_raw = 1'b0;
    tick(60);
    check("t1_nickel_count", count_typ(1), 1);
    check("t1_dime_count", count_typ(2), 0);
    check("t1_reject", n_rej, 0);
    check("t1_latency", ev_cyc.size() > 0 ? ev_cyc[0] - t0 : -1, 21);
    check("t1_busy_idle", busy, 0);

    // 2: bouncing dime gives one coin; a 10-cycle glitch gives none
    clear_log();
    dime_raw = 1'b1; tick(5);
    dime_raw = 1'b0; tick(5);
    dime_raw = 1'b1; tick(5);
    dime_raw = 1'b0; tick(5);
    dime_raw = 1'b1; tick(30);
    dime_raw = 1'b0; tick(40);
    check("t2_bounce_dime", count_typ(2), 1);
    check("t2_bounce_nickel", count_typ(1), 0);
    clear_log();
    dime_raw = 1'b1; tick(10);
    dime_raw = 1'b0; tick(40);
    check("t2_glitch_pulses", ev_cyc.size(), 0);
    check("t2_glitch_reject", n_rej, 0);

    // 3: held queue drains dime-first with full spacing
    clear_log();
    tx_hold = 1'b1;
    insert(1, 0); insert(1, 0); insert(1, 0);
    insert(0, 1); insert(0, 1);
    check("t3_held_no_pulse", ev_cyc.size(), 0);
    check("t3_held_busy", busy, 1);
    tx_hold = 1'b0;
    tick(60);
    check("t3_order", seq_code(), 22211);
    check("t3_spacing", min_space(), 6);
    check("t3_busy_done", busy, 0);

    // 4: nickel queue saturates at 7; disabled dime is rejected
    clear_log();
    tx_hold = 1'b1;
    for (int i = 0; i < 8; i++) insert(0, 1);
    check("t4_full_reject", n_rej, 1);
    accept_en = 1'b0;
    insert(1, 0);
    check("t4_disabled_reject", n_rej, 2);
    accept_en = 1'b1;
    tx_hold = 1'b0;
    tick(80);
    check("t4_nickels_out", count_typ(1), 7);
    check("t4_dimes_out", count_typ(2), 0);
    check("t4_spacing", min_space(), 6);

    // 5: simultaneous coins, dime at 21 then nickel 6 cycles later
    clear_log();
    t0 = cyc;
    insert(1, 1);
    tick(40);
    check("t5_order", seq_code(), 21);
    check("t5_dime_latency", ev_cyc.size() > 0 ? ev_cyc[0] - t0 : -1, 21);
    check("t5_spacing", ev_cyc.size() > 1 ? ev_cyc[1] - ev_cyc[0] : -1, 6);
    check("t5_reject", n_rej, 0);

    // 6: reset during GAP with two nickels still queued
    tx_hold = 1'b1;
    insert(0, 1); insert(0, 1); insert(0, 1);
    clear_log();
    tx_hold = 1'b0;
    for (int k = 0; k < 20 && ev_cyc.size() == 0; k++) tick(1);
    check("t6_first_pulse", ev_cyc.size(), 1);
    tick(2);
    check("t6_busy_in_gap", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_nickel_in", nickel_in, 0);
    check("t6_rst_dime_in", dime_in, 0);
    check("t6_rst_coin_reject", coin_reject, 0);
    check("t6_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    tick(100);
    check("t6_no_pulses", ev_cyc.size(), 0);
    check("t6_busy_after", busy, 0);

    check("never_both_high", both_hi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
